register_dump: RTL and testbench
================================

# register_dump

Debug read-out engine that sits on the second read port of the register file and streams a range of architectural registers out over a 1-bit valid/ready serial link. It walks register addresses from a start to an end address, snapshots each 32-bit word on a fetch cycle, and shifts it out LSB first. It gives the tiny core post-silicon visibility of register state through a single output pin plus handshake.

## Interface
- NUM_REGS, 32, number of architectural registers
- XLEN, 32, register width in bits
- ADDR_WIDTH, 5, register address width, $clog2(NUM_REGS)

- clock  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high; returns block to IDLE
- start  in  1  request a dump; sampled only in IDLE
- first_address  in  ADDR_WIDTH  first register to send, latched on accepted start
- last_address  in  ADDR_WIDTH  last register to send, latched on accepted start
- read_address  out  ADDR_WIDTH  drives register-file read port
- read_data  in  XLEN  combinational read data for read_address
- serial_out  out  1  current data bit, LSB of word first
- serial_valid  out  1  serial_out holds a valid bit
- serial_ready  in  1  receiver accepts bit this cycle
- frame_start  out  1  high with serial_valid on bit 0 of each word
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse after last bit of last word is accepted

## Operation
- States: IDLE, FETCH, SHIFT, DONE.
- IDLE: start=1 latches first/last addresses, sets address counter = first_address, -> FETCH. start=0 stays.
- FETCH: read_address = address counter; shift register loads read_data; bit counter cleared; -> SHIFT. Exactly one cycle.
- SHIFT: serial_valid=1, serial_out = shift[0], frame_start = (bit counter == 0). Transfer when serial_valid && serial_ready: shift right by one, bit counter +1.
- On transfer of bit XLEN-1: if address counter == last latched address -> DONE; else address counter +1 (mod NUM_REGS) -> FETCH.
- DONE: done=1, -> IDLE.
- Range wraps: first=30, last=1 sends 30,31,0,1. first==last sends one word. Full dump is first=0, last=31.
- Register 0 is read like any other; it returns whatever the register file supplies.
- Word is snapshotted in FETCH. Register-file writes during SHIFT do not alter the word being sent. A write to a later register before its FETCH is visible.
- start while busy is ignored; latched addresses do not change mid-dump.
- serial_out, frame_start = 0 whenever serial_valid = 0.

## Timing
- Reset values, one edge after reset=1: state IDLE, read_address 0, serial_out 0, serial_valid 0, frame_start 0, busy 0, done 0, counters 0.
- Reset mid-dump aborts immediately. No done pulse. The partial word is dropped.
- Start accepted at edge N: FETCH in cycle N+1, first serial_valid in cycle N+2.
- With serial_ready held high, each word takes XLEN+1 cycles (1 FETCH + 32 SHIFT). A k-word dump raises done exactly k*33+1 cycles after the start edge.
- While serial_valid && !serial_ready: serial_out, frame_start, and the counters hold stable.
- read_address changes only on entry to FETCH. It holds its last value through SHIFT, DONE and IDLE.
- done and start in the same cycle: start is not accepted, because the block is in DONE and not IDLE. It can be accepted on the next cycle in IDLE.

## Structure
- Shared package tiny_riscv_pkg holds XLEN, NUM_REGS and REG_ADDR_WIDTH. These constants are shared with register_file and the core.
- Local state enum typedef: register_dump_state_t with values IDLE, FETCH, SHIFT, DONE. It lives in the same package for bench visibility.
- One natural sub-module: word_serializer. It holds the XLEN shift register, the bit counter, and the valid/ready/frame_start logic. It has a load pulse in and a last_bit_accepted pulse out.
- The top level holds the FSM, the address counter, and the latched range.

## Test plan
- Single word: register 5 = 0xA5A5_0F0F, start with first=last=5, ready high. Required: bits 1,1,1,1,0,0,0,0,... LSB first, frame_start on the first bit only, done 34 cycles after the start edge.
- Full dump: registers i = i*0x0101_0101, range 0..31, ready high. Required: 32 frames in address order, each matching, and done at cycle 1057.
- Wrap range: first=30, last=1. Required: read_address sequence 30, 31, 0, 1, four frames, then done.
- Backpressure: ready toggles 1,0,0,1 in a pattern. Required: serial_out and frame_start stable while stalled, no bit lost or duplicated, and the word decodes correctly.
- Snapshot/collision: write register 3 = 0xFFFF_FFFF in the middle of sending register 3 (old value 0). Required: the frame carries 0. Also assert start while busy; required: ignored.
- Reset mid-dump: assert reset during bit 10 of the second word. Required: next cycle all outputs 0 and busy 0, no done pulse, and a new start works normally.

Source files
------------

// File: rtl/tiny_riscv_pkg.sv
// Constants shared by register_file, the core and the debug register dump engine,
// plus the dump engine's state type so benches can observe it by name.
package tiny_riscv_pkg;

    localparam int unsigned XLEN           = 32;
    localparam int unsigned NUM_REGS       = 32;
    localparam int unsigned REG_ADDR_WIDTH = $clog2(NUM_REGS);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        SHIFT,
        DONE
    } register_dump_state_t;

endpackage

// File: rtl/word_serializer.sv
// Shifts one XLEN-bit word out LSB first over a valid/ready link; a load pulse
// captures the word, and last_bit_accepted flags the handshake of the final bit.
module word_serializer
    import tiny_riscv_pkg::*;
#(
    parameter int unsigned WIDTH = XLEN
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] word,
    input  logic             serial_ready,
    output logic             serial_out,
    output logic             serial_valid,
    output logic             frame_start,
    output logic             last_bit_accepted
);

    localparam int unsigned COUNT_WIDTH = $clog2(WIDTH);

    logic [WIDTH-1:0]       shift_q;
    logic [COUNT_WIDTH-1:0] bit_count_q;
    logic                   valid_q;
    logic                   transfer;

    assign transfer          = valid_q && serial_ready;
    assign last_bit_accepted = transfer && (bit_count_q == COUNT_WIDTH'(WIDTH - 1));

    always_ff @(posedge clock) begin
        if (reset) begin
            shift_q     <= '0;
            bit_count_q <= '0;
            valid_q     <= 1'b0;
        end else if (load) begin
            shift_q     <= word;
            bit_count_q <= '0;
            valid_q     <= 1'b1;
        end else if (transfer) begin
            shift_q <= shift_q >> 1;
            if (last_bit_accepted) begin
                bit_count_q <= '0;
                valid_q     <= 1'b0;
            end else begin
                bit_count_q <= bit_count_q + 1'b1;
            end
        end
    end

    // Data and framing are forced low whenever nothing valid is on the link.
    assign serial_valid = valid_q;
    assign serial_out   = valid_q && shift_q[0];
    assign frame_start  = valid_q && (bit_count_q == '0);

endmodule

// File: rtl/register_dump.sv
// Debug read-out engine: walks a (wrapping) register address range on the
// register file's second read port and streams each word out serially.
module register_dump
    import tiny_riscv_pkg::*;
#(
    parameter int unsigned NUM_REGS   = tiny_riscv_pkg::NUM_REGS,
    parameter int unsigned XLEN       = tiny_riscv_pkg::XLEN,
    parameter int unsigned ADDR_WIDTH = REG_ADDR_WIDTH
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] first_address,
    input  logic [ADDR_WIDTH-1:0] last_address,
    output logic [ADDR_WIDTH-1:0] read_address,
    input  logic [XLEN-1:0]       read_data,
    output logic                  serial_out,
    output logic                  serial_valid,
    input  logic                  serial_ready,
    output logic                  frame_start,
    output logic                  busy,
    output logic                  done
);

    register_dump_state_t  state_q, state_d;
    logic [ADDR_WIDTH-1:0] address_q;
    logic [ADDR_WIDTH-1:0] last_q;
    logic                  load;
    logic                  accept_start;
    logic                  advance;
    logic                  last_bit_accepted;

    always_comb begin
        state_d      = state_q;
        load         = 1'b0;
        accept_start = 1'b0;
        advance      = 1'b0;
        busy         = 1'b1;
        done         = 1'b0;
        case (state_q)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    accept_start = 1'b1;
                    state_d      = FETCH;
                end
            end
            FETCH: begin
                load    = 1'b1;
                state_d = SHIFT;
            end
            SHIFT: begin
                if (last_bit_accepted) begin
                    if (address_q == last_q) begin
                        state_d = DONE;
                    end else begin
                        advance = 1'b1;
                        state_d = FETCH;
                    end
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // The address counter doubles as read_address, so it only moves on FETCH entry.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            address_q <= '0;
            last_q    <= '0;
        end else begin
            state_q <= state_d;
            if (accept_start) begin
                address_q <= first_address;
                last_q    <= last_address;
            end else if (advance) begin
                address_q <= (address_q == ADDR_WIDTH'(NUM_REGS - 1)) ? '0 : address_q + 1'b1;
            end
        end
    end

    assign read_address = address_q;

    word_serializer #(
        .WIDTH(XLEN)
    ) u_word_serializer (
        .clock             (clock),
        .reset             (reset),
        .load              (load),
        .word              (read_data),
        .serial_ready      (serial_ready),
        .serial_out        (serial_out),
        .serial_valid      (serial_valid),
        .frame_start       (frame_start),
        .last_bit_accepted (last_bit_accepted)
    );

endmodule

// File: tb/tb_register_dump.sv
// Randomized bench for register_dump: acts as the register file and the serial
// receiver, and compares decoded frames against a range/snapshot model.
module tb_register_dump;
    import tiny_riscv_pkg::*;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic [4:0]  first_address;
    logic [4:0]  last_address;
    logic [4:0]  read_address;
    logic [31:0] read_data;
    logic        serial_out;
    logic        serial_valid;
    logic        serial_ready;
    logic        frame_start;
    logic        busy;
    logic        done;

    logic [31:0] regs [32];
    assign read_data = regs[read_address];

    always #5 clock = ~clock;

    register_dump #(
        .NUM_REGS   (32),
        .XLEN       (32),
        .ADDR_WIDTH (5)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .start         (start),
        .first_address (first_address),
        .last_address  (last_address),
        .read_address  (read_address),
        .read_data     (read_data),
        .serial_out    (serial_out),
        .serial_valid  (serial_valid),
        .serial_ready  (serial_ready),
        .frame_start   (frame_start),
        .busy          (busy),
        .done          (done)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // Receiver state
    bit          monitor_on = 1'b0;
    int          ready_mode = 0;
    int          pat_idx    = 0;
    int          rx_bits    = 0;
    logic [31:0] rx_word;
    logic [31:0] rx_words[$];
    logic [4:0]  rx_addrs[$];
    bit          prev_stall = 1'b0;
    logic        prev_out, prev_fs;

    task automatic rx_clear();
        rx_bits    = 0;
        rx_word    = '0;
        rx_words   = {};
        rx_addrs   = {};
        prev_stall = 1'b0;
    endtask

    // One clock: drive ready at the falling edge, then observe the link.
    task automatic tick();
        @(negedge clock);
        case (ready_mode)
            0:       serial_ready = 1'b1;
            1:       begin serial_ready = (pat_idx % 4 == 0) || (pat_idx % 4 == 3); pat_idx++; end
            default: serial_ready = 1'($urandom_range(0, 1));
        endcase
        #1;
        if (monitor_on) begin
            if (prev_stall) begin
                check_eq("stall_serial_out", serial_out, prev_out);
                check_eq("stall_frame_start", frame_start, prev_fs);
            end
            if (!serial_valid) begin
                check_eq("idle_serial_out", serial_out, 0);
                check_eq("idle_frame_start", frame_start, 0);
            end
            if (serial_valid && serial_ready) begin
                check_eq("frame_start_bit", frame_start, (rx_bits == 0));
                if (rx_bits == 0) rx_addrs.push_back(read_address);
                rx_word[rx_bits] = serial_out;
                rx_bits++;
                if (rx_bits == 32) begin
                    rx_words.push_back(rx_word);
                    rx_bits = 0;
                end
            end
            prev_stall = serial_valid && !serial_ready;
            prev_out   = serial_out;
            prev_fs    = frame_start;
        end
    endtask

    task automatic run_dump(input int f, input int l, input int mode, input bit check_lat,
                            input bit poke_start, input bit collide);
        logic [4:0]  addrs[$];
        logic [31:0] words[$];
        int a, lat, budget;
        bit got_done;
        a = f;
        forever begin
            addrs.push_back(5'(a));
            words.push_back(regs[a]);
            if (a == l) break;
            a = (a + 1) % 32;
        end
        budget = addrs.size() * 33 * 8 + 20;
        rx_clear();
        ready_mode = mode;
        pat_idx    = 0;
        check_eq("idle_busy_before_start", busy, 0);
        first_address = 5'(f);
        last_address  = 5'(l);
        start = 1'b1;
        tick();
        start = 1'b0;
        lat = 1;
        check_eq("fetch_busy", busy, 1);
        check_eq("fetch_no_valid", serial_valid, 0);
        check_eq("fetch_read_address", read_address, 32'(f));
        got_done = done;
        while (!got_done && lat < budget) begin
            if (poke_start && lat == 40) begin
                start         = 1'b1;
                first_address = 5'(f + 9);
                last_address  = 5'(f + 11);
            end
            if (collide && lat == 20) begin
                regs[f] = 32'hFFFF_FFFF;
                if (words.size() > 1) begin
                    regs[(f + 1) % 32] = 32'h1234_5678;
                    words[1] = 32'h1234_5678;
                end
            end
            tick();
            start = 1'b0;
            lat++;
            got_done = done;
        end
        check_eq("done_seen", got_done, 1);
        if (check_lat) check_eq("done_latency", lat, addrs.size() * 33 + 1);
        check_eq("frame_count", rx_words.size(), addrs.size());
        check_eq("partial_bits", rx_bits, 0);
        for (int j = 0; j < addrs.size() && j < rx_words.size(); j++) begin
            check_eq($sformatf("word[%0d]", j), rx_words[j], words[j]);
            check_eq($sformatf("addr[%0d]", j), rx_addrs[j], addrs[j]);
        end
        check_eq("addr_hold_done", read_address, 32'(l));
        tick();
        check_eq("done_one_pulse", done, 0);
        check_eq("busy_after_done", busy, 0);
        check_eq("addr_hold_idle", read_address, 32'(l));
    endtask

    task automatic reset_mid_dump();
        bit saw_done;
        for (int i = 0; i < 32; i++) regs[i] = $urandom;
        rx_clear();
        ready_mode    = 0;
        first_address = 5'd0;
        last_address  = 5'd3;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (rx_words.size() == 1 && rx_bits == 10) break;
            tick();
        end
        check_eq("reached_word1_bit10", rx_bits, 10);
        tick();
        reset = 1'b1;
        tick();
        prev_stall = 1'b0;
        check_eq("rst_serial_out", serial_out, 0);
        check_eq("rst_serial_valid", serial_valid, 0);
        check_eq("rst_frame_start", frame_start, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_read_address", read_address, 0);
        reset = 1'b0;
        rx_clear();
        saw_done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (done) saw_done = 1'b1;
        end
        check_eq("no_done_after_reset", saw_done, 0);
        check_eq("no_bits_after_reset", rx_bits, 0);
        run_dump(2, 4, 0, 1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        int f, k, mode;
        reset        = 1'b1;
        start        = 1'b0;
        serial_ready = 1'b0;
        first_address = '0;
        last_address  = '0;
        for (int i = 0; i < 32; i++) regs[i] = '0;
        tick();
        tick();
        monitor_on = 1'b1;
        check_eq("reset_read_address", read_address, 0);
        check_eq("reset_serial_out", serial_out, 0);
        check_eq("reset_serial_valid", serial_valid, 0);
        check_eq("reset_frame_start", frame_start, 0);
        check_eq("reset_busy", busy, 0);
        check_eq("reset_done", done, 0);
        reset = 1'b0;
        tick();

        // Single word
        regs[5] = 32'hA5A5_0F0F;
        run_dump(5, 5, 0, 1'b1, 1'b0, 1'b0);

        // Full dump
        for (int i = 0; i < 32; i++) regs[i] = i * 32'h0101_0101;
        run_dump(0, 31, 0, 1'b1, 1'b0, 1'b0);

        // Wrapping range
        run_dump(30, 1, 0, 1'b1, 1'b0, 1'b0);

        // Backpressure with the 1,0,0,1 pattern
        regs[7] = 32'h8C3E_61D5;
        regs[8] = 32'h0000_0001;
        run_dump(7, 8, 1, 1'b0, 1'b0, 1'b0);

        // Snapshot collision and start while busy
        regs[3] = 32'h0000_0000;
        regs[4] = 32'h5555_AAAA;
        run_dump(3, 4, 0, 1'b1, 1'b1, 1'b1);

        reset_mid_dump();

        // Random ranges, data and ready behaviour
        for (int n = 0; n < 10; n++) begin
            for (int i = 0; i < 32; i++) regs[i] = $urandom;
            f    = int'($urandom_range(0, 31));
            k    = int'($urandom_range(0, 7));
            mode = int'($urandom_range(0, 2));
            run_dump(f, (f + k) % 32, mode, mode == 0, 1'(n % 2), 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
